// File: rtl/mem_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_scheduler
// Purpose  : Round-robin multi-channel burst read scheduler with tagged,
//            out-of-order response routing. Optional tag checking is enabled
//            with MEM_RD_TAG_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rd_scheduler #(
    parameter  int NUM_CH    = 4,
    parameter  int ADDR_W    = 64,
    parameter  int LINE_W    = 512,
    parameter  int MAX_LINES = 16,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int IDX_W     = $clog2(MAX_LINES),
    localparam int LCNT_W    = IDX_W + 1,
    localparam int TAG_W     = CH_W + IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LCNT_W-1:0] req_lines,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [TAG_W-1:0]         rd_tag,
    input  logic                     rd_almost_full,
    input  logic                     rx_valid,
    input  logic [TAG_W-1:0]         rx_tag,
    input  logic [LINE_W-1:0]        rx_data,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic [IDX_W-1:0]         out_idx,
    output logic [LINE_W-1:0]        out_data,
    output logic                     out_last,
    output logic [NUM_CH-1:0]        done,
    output logic                     err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_ch;
    logic [ADDR_W-1:0]   r_base;
    logic [LCNT_W-1:0]   r_lines;
    logic [LCNT_W-1:0]   r_idx;
    logic [LCNT_W-1:0]   r_rem [NUM_CH];
    logic [NUM_CH-1:0]   w_busy;

    logic [CH_W-1:0]     w_cand;
    logic [CH_W-1:0]     w_gnt_ch;
    logic                w_gnt_found;
    logic                w_accept;
    logic [LCNT_W-1:0]   w_req_lines;
    logic [LCNT_W-1:0]   w_lines_sel;
    logic                w_issue;
    logic                w_issue_last;

    logic [CH_W-1:0]     w_rx_ch;
    logic [IDX_W-1:0]    w_rx_idx;
    logic                w_rx_ch_ok;
    logic [LCNT_W-1:0]   w_rx_rem;
    logic                w_rx_final;
    logic                w_hit;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // A channel stays busy until every line of its request has been returned.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_busy
        assign w_busy[g] = (r_rem[g] != '0);
    end

    always_comb begin
        w_cand      = '0;
        w_gnt_ch    = '0;
        w_gnt_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = wrap_add(r_rr_ptr, i);
            if (!w_gnt_found && req_valid[w_cand] && !w_busy[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = w_cand;
            end
        end
    end

    assign w_accept     = (r_state == S_IDLE) && w_gnt_found && !rst;
    assign req_ready    = w_accept ? (NUM_CH'(1) << w_gnt_ch) : '0;
    assign w_req_lines  = req_lines[w_gnt_ch*LCNT_W +: LCNT_W];
    assign w_lines_sel  = (w_req_lines == '0) ? LCNT_W'(1) : w_req_lines;
    assign w_issue      = (r_state == S_ISSUE) && !rd_almost_full;
    assign w_issue_last = w_issue && (r_idx == (r_lines - LCNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_issue_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_tag   <= '0;
            r_rr_ptr <= '0;
            r_ch     <= '0;
            r_base   <= '0;
            r_lines  <= '0;
            r_idx    <= '0;
        end else begin
            rd_valid <= w_issue;
            if (w_accept) begin
                r_ch     <= w_gnt_ch;
                r_base   <= req_addr[w_gnt_ch*ADDR_W +: ADDR_W];
                r_lines  <= w_lines_sel;
                r_idx    <= '0;
                r_rr_ptr <= wrap_add(w_gnt_ch, 1);
            end
            if (w_issue) begin
                rd_addr <= r_base + ADDR_W'(r_idx) * ADDR_W'(LINE_W / 8);
                rd_tag  <= {r_ch, r_idx[IDX_W-1:0]};
                r_idx   <= r_idx + LCNT_W'(1);
            end
        end
    end

    assign w_rx_ch    = rx_tag[TAG_W-1 -: CH_W];
    assign w_rx_idx   = rx_tag[IDX_W-1:0];
    assign w_rx_ch_ok = ({1'b0, w_rx_ch} < (CH_W + 1)'(NUM_CH));
    assign w_rx_rem   = w_rx_ch_ok ? r_rem[w_rx_ch] : '0;
    assign w_rx_final = (w_rx_rem == LCNT_W'(1));

`ifdef MEM_RD_TAG_CHECK_EN
    logic [LCNT_W-1:0] r_lcnt [NUM_CH];
    logic [LCNT_W-1:0] w_rx_lcnt;
    logic              r_err;

    assign w_rx_lcnt = w_rx_ch_ok ? r_lcnt[w_rx_ch] : '0;
    assign w_hit     = rx_valid && (w_rx_rem != '0) && ({1'b0, w_rx_idx} < w_rx_lcnt);
    assign err       = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lcnt
        always_ff @(posedge clk) begin
            if (rst)                                        r_lcnt[g] <= '0;
            else if (w_accept && (w_gnt_ch == CH_W'(g)))    r_lcnt[g] <= w_lines_sel;
        end
    end

    // Anything on rx that is not forwarded is a tag error.
    always_ff @(posedge clk) begin
        if (rst)                    r_err <= 1'b0;
        else if (rx_valid && !w_hit) r_err <= 1'b1;
    end
`else
    assign w_hit = rx_valid && (w_rx_rem != '0);
    assign err   = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rem
        always_ff @(posedge clk) begin
            if (rst)                                     r_rem[g] <= '0;
            else if (w_accept && (w_gnt_ch == CH_W'(g))) r_rem[g] <= w_lines_sel;
            else if (w_hit && (w_rx_ch == CH_W'(g)))     r_rem[g] <= r_rem[g] - LCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= '0;
            out_ch    <= '0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= w_hit;
            out_last  <= w_hit && w_rx_final;
            done      <= (w_hit && w_rx_final) ? (NUM_CH'(1) << w_rx_ch) : '0;
            if (w_hit) begin
                out_ch   <= w_rx_ch;
                out_idx  <= w_rx_idx;
                out_data <= rx_data;
            end
        end
    end

endmodule
`default_nettype wire
